dsp_bus_arbiter: RTL and testbench

//  Shares the single DSP I/O bus among NUM_REQ bus sequencers (reset, command-write, data-read, ...).

---
 rtl/dsp_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_dsp_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_bus_arbiter.sv
// dsp_bus_arbiter
// Shares the DSP I/O bus among NUM_REQ sequencers with one-hot enables,
// round-robin selection and a turnaround gap between owners. After reset
// only requester 0 (the DSP reset sequence) is served until it completes.
// Optional grant watchdog: define DSP_BUS_ARB_TIMEOUT_EN.
module dsp_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int GAP_CYCLES = 2
`ifdef DSP_BUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                bus_clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                accepted,
    output logic [NUM_REQ-1:0]  enable,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);
    localparam logic [3:0]         GAP_LOAD  = 4'(GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  enable_q, enable_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                first_q, first_d;
    logic                boot_done_q, boot_done_d;
    logic [3:0]          gap_q, gap_d;

    logic                pick_valid;
    logic [ID_WIDTH-1:0] pick_id;
    logic                start_grant;
    logic [ID_WIDTH-1:0] start_id;
    logic                end_grant;

`ifdef DSP_BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TMR_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] tmr_q, tmr_d;
`endif

    // Requester index base+off, wrapping at NUM_REQ-1 back to 0.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_WIDTH'(sum);
    endfunction

    // Round-robin pick: first requester at or above rr_ptr, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        // Scan from the far end so the nearest requester is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(rr_ptr_q, i)]) begin
                pick_valid = 1'b1;
                pick_id    = wrap_add(rr_ptr_q, i);
            end
        end
    end

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        enable_d    = enable_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        first_d     = 1'b0;
        boot_done_d = boot_done_q;
        gap_d       = gap_q;
        start_grant = 1'b0;
        start_id    = '0;
        end_grant   = 1'b0;
`ifdef DSP_BUS_ARB_TIMEOUT_EN
        tmr_d       = tmr_q;
`endif

        case (state_q)
            ST_BOOT: begin
                if (req[0]) begin
                    start_grant = 1'b1;
                    start_id    = '0;
                end
            end
            ST_IDLE: begin
                if (pick_valid) begin
                    start_grant = 1'b1;
                    start_id    = pick_id;
                end
            end
            ST_GRANT: begin
`ifdef DSP_BUS_ARB_TIMEOUT_EN
                tmr_d = tmr_q + 16'd1;
`endif
                // accepted is only looked at here; the first cycle lets the bus settle.
                if (!first_q && accepted) begin
                    done_d    = 1'b1;
                    end_grant = 1'b1;
                    if (!boot_done_q) boot_done_d = 1'b1;
                end
`ifdef DSP_BUS_ARB_TIMEOUT_EN
                else if (tmr_q == TMR_LIMIT) begin
                    timeout_d = 1'b1;
                    end_grant = 1'b1;
                end
`endif
                else if (!first_q && !req[grant_id_q]) begin
                    end_grant = 1'b1;
                end

                if (end_grant) begin
                    enable_d = '0;
                    state_d  = ST_RELEASE;
                    gap_d    = GAP_LOAD;
                    rr_ptr_d = wrap_add(grant_id_q, 1);
                end
            end
            ST_RELEASE: begin
                // Last gap cycle hands straight to the next owner so the gap is exact.
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!boot_done_q) begin
                    state_d = ST_BOOT;
                end else if (pick_valid) begin
                    start_grant = 1'b1;
                    start_id    = pick_id;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (start_grant) begin
            state_d    = ST_GRANT;
            enable_d   = ONE_HOT_0 << start_id;
            grant_id_d = start_id;
            first_d    = 1'b1;
`ifdef DSP_BUS_ARB_TIMEOUT_EN
            tmr_d      = 16'd1;
`endif
        end

        busy_d = (state_d == ST_GRANT) || (state_d == ST_RELEASE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge bus_clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_BOOT;
            enable_q    <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= ID_WIDTH'(1);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            first_q     <= 1'b0;
            boot_done_q <= 1'b0;
            gap_q       <= '0;
`ifdef DSP_BUS_ARB_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            first_q     <= first_d;
            boot_done_q <= boot_done_d;
            gap_q       <= gap_d;
`ifdef DSP_BUS_ARB_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign enable   = enable_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_dsp_bus_arbiter.sv
// Testbench for dsp_bus_arbiter: scenario tasks with a grant-order scoreboard.
// Build with DSP_BUS_ARB_TIMEOUT_EN defined to also cover the watchdog.
module tb_dsp_bus_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int GAP_CYCLES = 2;
`ifdef DSP_BUS_ARB_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 20;
    localparam int COMPLETE_CYCLE = 15;
`else
    localparam int COMPLETE_CYCLE = 30;
`endif

    logic                bus_clock = 1'b0;
    logic                reset;
    logic [NUM_REQ-1:0]  req;
    logic                accepted;
    logic [NUM_REQ-1:0]  enable;
    logic [ID_WIDTH-1:0] grant_id;
    logic                busy;
    logic                done;
    logic                timeout;

    int passed = 0;
    int total  = 0;
    int exp_q[$];

    dsp_bus_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ID_WIDTH  (ID_WIDTH),
`ifdef DSP_BUS_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
`endif
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .bus_clock(bus_clock),
        .reset    (reset),
        .req      (req),
        .accepted (accepted),
        .enable   (enable),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 bus_clock = ~bus_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic tick();
        @(posedge bus_clock);
        #1;
    endtask

    // Wait up to max_cycles edges for any enable; low counts enable-low edges seen.
    task automatic wait_grant(input int max_cycles, output int low, output bit ok);
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (enable != '0) begin
                ok = 1'b1;
                break;
            end
            low++;
        end
    endtask

    function automatic int sb_pop();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] one;
        one = NUM_REQ'(1);
        if (id < 0) return '0;
        return one << id;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        accepted = 1'bz;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (enable !== 4'b0000) $display("FAIL reset_enable: got %b expected 0000", enable); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout); else passed++;
    endtask

    task automatic test_boot_lock();
        int seen;
        int id;
        seen = 0;
        req  = 4'b1110;
        repeat (6) begin
            tick();
            if (enable !== 4'b0000 || busy !== 1'b0) seen++;
        end
        total++; if (seen != 0) $display("FAIL boot_ignore: %0d cycles granted, expected 0", seen); else passed++;
        req = 4'b1111;
        exp_q.push_back(0);
        tick();
        id = sb_pop();
        total++; if (enable !== onehot(id)) $display("FAIL boot_enable: got %b expected %b", enable, onehot(id)); else passed++;
        total++; if (grant_id !== ID_WIDTH'(id)) $display("FAIL boot_grant_id: got %0d expected %0d", grant_id, id); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL boot_busy: got %b expected 1", busy); else passed++;
    endtask

    task automatic test_completion();
        int bad;
        bad      = 0;
        accepted = 1'b0;
        repeat (COMPLETE_CYCLE - 1) begin
            tick();
            if (enable !== 4'b0001 || done !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL hold_grant: %0d bad cycles, expected 0", bad); else passed++;
        accepted = 1'b1;
        tick();
        total++; if (done !== 1'b1) $display("FAIL done_pulse: got %b expected 1", done); else passed++;
        total++; if (enable !== 4'b0000) $display("FAIL done_enable: got %b expected 0000", enable); else passed++;
        accepted = 1'bz;
        req      = 4'b1110;
        tick();
        total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done); else passed++;
        total++; if (enable !== 4'b0000 || busy !== 1'b1) $display("FAIL gap_state: enable %b busy %b expected 0000 1", enable, busy); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL gap_grant_id: got %0d expected 0", grant_id); else passed++;
    endtask

    task automatic test_round_robin();
        int low;
        bit ok;
        int id;
        req = 4'b1111;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(1);
        for (int k = 0; k < 5; k++) begin
            wait_grant(8, low, ok);
            total++; if (!ok) $display("FAIL rr_wait: no grant %0d within 8 cycles", k); else passed++;
            id = sb_pop();
            total++; if (enable !== onehot(id)) $display("FAIL rr_enable: got %b expected %b", enable, onehot(id)); else passed++;
            total++; if (grant_id !== ID_WIDTH'(id)) $display("FAIL rr_grant_id: got %0d expected %0d", grant_id, id); else passed++;
            if (k > 0) begin
                total++; if (low + 1 != GAP_CYCLES) $display("FAIL rr_gap: got %0d expected %0d", low + 1, GAP_CYCLES); else passed++;
            end
            // accepted in the first grant cycle must be ignored
            accepted = 1'b1;
            tick();
            total++; if (done !== 1'b0 || enable !== onehot(id)) $display("FAIL rr_first_cycle: done %b enable %b expected 0 %b", done, enable, onehot(id)); else passed++;
            tick();
            total++; if (done !== 1'b1 || enable !== 4'b0000) $display("FAIL rr_done: done %b enable %b expected 1 0000", done, enable); else passed++;
            accepted = 1'bz;
        end
        req = '0;
        repeat (3) tick();
        total++; if (busy !== 1'b0 || enable !== 4'b0000) $display("FAIL idle_state: busy %b enable %b expected 0 0000", busy, enable); else passed++;
        total++; if (grant_id !== 2'd1) $display("FAIL idle_grant_id: got %0d expected 1", grant_id); else passed++;
    endtask

    task automatic test_abandon();
        int low;
        bit ok;
        int id;
        req = 4'b1100;
        exp_q.push_back(2);
        exp_q.push_back(3);
        wait_grant(4, low, ok);
        total++; if (!ok) $display("FAIL ab_wait: no grant within 4 cycles"); else passed++;
        id = sb_pop();
        total++; if (enable !== onehot(id)) $display("FAIL ab_enable: got %b expected %b", enable, onehot(id)); else passed++;
        accepted = 1'b0;
        repeat (4) tick();
        req = 4'b1000;
        tick();
        total++; if (enable !== 4'b0000 || done !== 1'b0 || busy !== 1'b1) $display("FAIL ab_release: enable %b done %b busy %b expected 0000 0 1", enable, done, busy); else passed++;
        accepted = 1'bz;
        wait_grant(8, low, ok);
        total++; if (!ok) $display("FAIL ab_wait_next: no grant within 8 cycles"); else passed++;
        id = sb_pop();
        total++; if (grant_id !== ID_WIDTH'(id) || enable !== onehot(id)) $display("FAIL ab_next_owner: got %0d/%b expected %0d/%b", grant_id, enable, id, onehot(id)); else passed++;
        total++; if (low + 1 != GAP_CYCLES) $display("FAIL ab_gap: got %0d expected %0d", low + 1, GAP_CYCLES); else passed++;
        tick();
        accepted = 1'b1;
        tick();
        total++; if (done !== 1'b1) $display("FAIL ab_next_done: got %b expected 1", done); else passed++;
        accepted = 1'bz;
        req      = '0;
    endtask

    task automatic test_reset_mid_grant();
        int low;
        bit ok;
        int id;
        int seen;
        req = 4'b0010;
        exp_q.push_back(1);
        wait_grant(6, low, ok);
        total++; if (!ok) $display("FAIL rm_wait: no grant within 6 cycles"); else passed++;
        id = sb_pop();
        total++; if (enable !== onehot(id)) $display("FAIL rm_enable: got %b expected %b", enable, onehot(id)); else passed++;
        accepted = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        total++; if (enable !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) $display("FAIL rm_reset: enable %b busy %b id %0d expected 0000 0 0", enable, busy, grant_id); else passed++;
        reset = 1'b0;
        seen  = 0;
        repeat (5) begin
            tick();
            if (enable !== 4'b0000) seen++;
        end
        total++; if (seen != 0) $display("FAIL rm_boot_ignore: %0d cycles granted, expected 0", seen); else passed++;
        req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_grant(3, low, ok);
        id = sb_pop();
        total++; if (!ok || grant_id !== ID_WIDTH'(id) || enable !== onehot(id)) $display("FAIL rm_boot_owner: got %0d/%b expected %0d/%b", grant_id, enable, id, onehot(id)); else passed++;
        tick();
        accepted = 1'b1;
        tick();
        total++; if (done !== 1'b1) $display("FAIL rm_boot_done: got %b expected 1", done); else passed++;
        accepted = 1'bz;
        req      = 4'b0010;
        wait_grant(6, low, ok);
        id = sb_pop();
        total++; if (!ok || grant_id !== ID_WIDTH'(id) || enable !== onehot(id)) $display("FAIL rm_after_boot: got %0d/%b expected %0d/%b", grant_id, enable, id, onehot(id)); else passed++;
        tick();
        accepted = 1'b1;
        tick();
        total++; if (done !== 1'b1) $display("FAIL rm_after_done: got %b expected 1", done); else passed++;
        accepted = 1'bz;
        req      = '0;
    endtask

`ifdef DSP_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int low;
        bit ok;
        int id;
        int bad;
        // Non-boot owner: watchdog expires with accepted held low.
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant(6, low, ok);
        id = sb_pop();
        total++; if (!ok || grant_id !== ID_WIDTH'(id)) $display("FAIL to_grant: got %0d expected %0d", grant_id, id); else passed++;
        accepted = 1'b0;
        bad      = 0;
        repeat (TIMEOUT_CYCLES - 1) begin
            tick();
            if (timeout !== 1'b0 || enable !== onehot(id)) bad++;
        end
        total++; if (bad != 0) $display("FAIL to_early: %0d bad cycles, expected 0", bad); else passed++;
        tick();
        total++; if (timeout !== 1'b1 || done !== 1'b0 || enable !== 4'b0000) $display("FAIL to_pulse: timeout %b done %b enable %b expected 1 0 0000", timeout, done, enable); else passed++;
        req = '0;
        tick();
        total++; if (timeout !== 1'b0) $display("FAIL to_one_cycle: got %b expected 0", timeout); else passed++;
        accepted = 1'bz;
        repeat (3) tick();
        // accepted on the limit cycle wins over the watchdog.
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant(6, low, ok);
        id = sb_pop();
        total++; if (!ok || grant_id !== ID_WIDTH'(id)) $display("FAIL to_lim_grant: got %0d expected %0d", grant_id, id); else passed++;
        accepted = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) tick();
        accepted = 1'b1;
        tick();
        total++; if (done !== 1'b1 || timeout !== 1'b0) $display("FAIL to_limit_accept: done %b timeout %b expected 1 0", done, timeout); else passed++;
        accepted = 1'bz;
        req      = '0;
        repeat (3) tick();
        // Boot owner: watchdog sends the arbiter back to BOOT to retry owner 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(0);
        wait_grant(4, low, ok);
        id = sb_pop();
        total++; if (!ok || enable !== onehot(id)) $display("FAIL to_boot_grant: got %b expected %b", enable, onehot(id)); else passed++;
        accepted = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) tick();
        tick();
        total++; if (timeout !== 1'b1 || done !== 1'b0) $display("FAIL to_boot_pulse: timeout %b done %b expected 1 0", timeout, done); else passed++;
        accepted = 1'bz;
        wait_grant(8, low, ok);
        id = sb_pop();
        total++; if (!ok || enable !== onehot(id) || grant_id !== ID_WIDTH'(id)) $display("FAIL to_boot_retry: got %0d/%b expected %0d/%b", grant_id, enable, id, onehot(id)); else passed++;
        tick();
        accepted = 1'b1;
        tick();
        total++; if (done !== 1'b1) $display("FAIL to_boot_done: got %b expected 1", done); else passed++;
        accepted = 1'bz;
        req      = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_boot_lock();
        test_completion();
        test_round_robin();
        test_abandon();
        test_reset_mid_grant();
`ifdef DSP_BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d grants still expected, expected 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
